// File: rtl/param_dp_arbiter_if.sv
// Request, datapath and response signals shared between the clients, the
// param_dp_arbiter and the shared combinational arithmetic unit.
interface param_dp_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_c;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  dp_c, rsp_ready,
        output req0_ready, req1_ready, dp_a, dp_b,
        output rsp_valid, rsp_id, rsp_data, busy, gnt_cnt0, gnt_cnt1
    );

    // Client / environment side
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output dp_c, rsp_ready,
        input  req0_ready, req1_ready, dp_a, dp_b,
        input  rsp_valid, rsp_id, rsp_data, busy, gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/param_dp_arbiter.sv
// Round-robin sharing of one combinational WIDTH-bit datapath between two requesters.
// Define ARB_STATS_EN to enable the per-requester grant counters gnt_cnt0/gnt_cnt1.
module param_dp_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    param_dp_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_gnt_q;
    logic             win;
    logic             accept;
    logic [WIDTH-1:0] opa_p0;
    logic [WIDTH-1:0] opb_p0;
    logic             id_p0;
    logic [WIDTH-1:0] res_p1;

    // Both valid: alternate away from the last grant; otherwise the lone requester wins.
    assign win = (bus.req0_valid && bus.req1_valid) ? ~last_gnt_q : bus.req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Readies are gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    accept         = 1'b1;
                    bus.req0_ready = ~win;
                    bus.req1_ready = win;
                    state_d        = ISSUE;
                end
            end
            ISSUE:   state_d = RESPOND;
            RESPOND: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: winner operands latched and driven onto the shared datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_p0     <= '0;
            opb_p0     <= '0;
            id_p0      <= 1'b0;
            last_gnt_q <= 1'b1;
        end else if (accept) begin
            opa_p0     <= win ? bus.req1_a : bus.req0_a;
            opb_p0     <= win ? bus.req1_b : bus.req0_b;
            id_p0      <= win;
            last_gnt_q <= win;
        end
    end

    // Stage p1: datapath result captured after its settle cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= '0;
        end else if (state_q == ISSUE) begin
            res_p1 <= bus.dp_c;
        end
    end

    assign bus.dp_a      = opa_p0;
    assign bus.dp_b      = opb_p0;
    assign bus.rsp_id    = id_p0;
    assign bus.rsp_data  = res_p1;
    assign bus.rsp_valid = (state_q == RESPOND);
    assign bus.busy      = (state_q != IDLE);

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (win) cnt1_q <= cnt1_q + 1'b1;
            else     cnt0_q <= cnt0_q + 1'b1;
        end
    end

    assign bus.gnt_cnt0 = cnt0_q;
    assign bus.gnt_cnt1 = cnt1_q;
`else
    assign bus.gnt_cnt0 = '0;
    assign bus.gnt_cnt1 = '0;
`endif
endmodule

// File: tb/tb_param_dp_arbiter.sv
// Scoreboard bench for param_dp_arbiter: a transaction-level model predicts grants
// and sums, a separate monitor checks every response against the queued prediction.
module tb_param_dp_arbiter;
    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    param_dp_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    // Truncating adder standing in for the shared datapath
    assign bus.dp_c = bus.dp_a + bus.dp_b;

    param_dp_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Reference model: one operation outstanding at a time, round-robin on contention.
    bit m_busy = 1'b0;
    bit m_last = 1'b1;
    int m_due  = 0;
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   has;
        bit   w;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_cnt0 = 0;
            m_cnt1 = 0;
            sb.delete();
            chk("rst_req0_ready", bus.req0_ready, 0);
            chk("rst_req1_ready", bus.req1_ready, 0);
            chk("rst_rsp_valid",  bus.rsp_valid, 0);
            chk("rst_busy",       bus.busy, 0);
            chk("rst_rsp_id",     bus.rsp_id, 0);
            chk("rst_rsp_data",   bus.rsp_data, 0);
            chk("rst_dp_a",       bus.dp_a, 0);
            chk("rst_dp_b",       bus.dp_b, 0);
            chk("rst_gnt_cnt0",   bus.gnt_cnt0, 0);
            chk("rst_gnt_cnt1",   bus.gnt_cnt1, 0);
        end else begin
`ifdef ARB_STATS_EN
            chk("gnt_cnt0", bus.gnt_cnt0, m_cnt0 % 256);
            chk("gnt_cnt1", bus.gnt_cnt1, m_cnt1 % 256);
`else
            chk("gnt_cnt0_tied", bus.gnt_cnt0, 0);
            chk("gnt_cnt1_tied", bus.gnt_cnt1, 0);
`endif
            if (!m_busy) begin
                has = bus.req0_valid || bus.req1_valid;
                if (bus.req0_valid && bus.req1_valid) w = !m_last;
                else if (bus.req0_valid)              w = 1'b0;
                else                                  w = 1'b1;
                chk("idle_req0_ready", bus.req0_ready, has && !w);
                chk("idle_req1_ready", bus.req1_ready, has && w);
                chk("idle_busy", bus.busy, 0);
                if (has) begin
                    e.id   = w;
                    e.data = w ? bus.req1_a + bus.req1_b : bus.req0_a + bus.req0_b;
                    e.due  = cyc + 2;
                    sb.push_back(e);
                    m_busy = 1'b1;
                    m_last = w;
                    m_due  = cyc + 2;
                    if (w) m_cnt1++;
                    else   m_cnt0++;
                end
            end else begin
                chk("busy_req0_ready", bus.req0_ready, 0);
                chk("busy_req1_ready", bus.req1_ready, 0);
                chk("busy_flag", bus.busy, 1);
                if (cyc >= m_due && bus.rsp_ready) m_busy = 1'b0;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb.size() == 0) begin
                chk("rsp_valid_none", bus.rsp_valid, 0);
            end else begin
                e = sb[0];
                if (cyc < e.due) begin
                    chk("rsp_valid_early", bus.rsp_valid, 0);
                end else begin
                    chk("rsp_valid", bus.rsp_valid, 1);
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_data", bus.rsp_data, e.data);
                    if (bus.rsp_valid && bus.rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] rand_op();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    // Random requester/consumer traffic; a pair is replaced only after acceptance.
    task automatic run(input int n, input int p0, input int p1, input int pr);
        bit a0;
        bit a1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk);
            #1;
            if (a0 || !bus.req0_valid) begin
                bus.req0_valid = (int'($urandom_range(99)) < p0);
                bus.req0_a     = rand_op();
                bus.req0_b     = rand_op();
            end else if (p0 < 100 && $urandom_range(9) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (a1 || !bus.req1_valid) begin
                bus.req1_valid = (int'($urandom_range(99)) < p1);
                bus.req1_a     = rand_op();
                bus.req1_b     = rand_op();
            end else if (p1 < 100 && $urandom_range(9) == 0) begin
                bus.req1_valid = 1'b0;
            end
            bus.rsp_ready = (int'($urandom_range(99)) < pr);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int  n0;
        bit  a0;
        bit  got;
        // Reset held with both requesters valid; req0 then req1 (wrap-around) go first.
        bus.req0_valid = 1'b1;
        bus.req0_a     = 32'h0000_0001;
        bus.req0_b     = 32'h0000_0012;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 32'hFFFF_FFFF;
        bus.req1_b     = 32'h0000_0001;
        bus.rsp_ready  = 1'b1;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(24, 100, 100, 100);
        run(12, 100, 100, 0);
        run(12, 100, 100, 100);
        run(300, 70, 60, 60);

        // Reset while an operation sits in ISSUE
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
        end
        chk("accept_before_reset", got, 1);
        pulse_reset();
        run(60, 80, 80, 80);

        // Exactly 257 back-to-back req0-only grants from reset
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        pulse_reset();
        n0 = 0;
        for (int i = 0; i < 2000 && n0 < 257; i++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            if (a0) n0++;
            @(posedge clk);
            #1;
            if (a0 || !bus.req0_valid) begin
                bus.req0_valid = (n0 < 257);
                bus.req0_a     = rand_op();
                bus.req0_b     = rand_op();
            end
        end
        chk("ops0_count", n0, 257);
        bus.req0_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
`ifdef ARB_STATS_EN
        chk("final_gnt_cnt0", bus.gnt_cnt0, 1);
`else
        chk("final_gnt_cnt0", bus.gnt_cnt0, 0);
`endif
        chk("final_gnt_cnt1", bus.gnt_cnt1, 0);
        chk("final_busy", bus.busy, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
